scheme_sequencer: RTL
=====================

// Module: scheme_sequencer
// PURPOSE
// - Downstream consumer of the pulse-width demodulator. Detects each newly decoded message
//   (change on ord), latches flag/scheme payloads, and serialises the 48-bit scheme onto the
//   tag modulation line, one burst per upstream packet trigger.
// - Drives working back to the demodulator so it flushes its partial frame while a burst is on air.
// PARAMETERS
// - BIT_CYCLES  50   base clocks per scheme bit; actual = BIT_CYCLES*(act_flag[3:0]+1)
// - GAP_CYCLES  500  idle clocks between repeated bursts
// - NBITS       48   scheme length; width of cur_scheme
// PORTS
// - clock       in   1   system clock
// - reset       in   1   synchronous, active-high reset
// - ord         in   2   demodulator message counter; any change = one new message
// - ctg         in   2   category of message: 01 abort, 10 flag, 11 scheme, 00 ignored
// - cur_flag    in   8   flag payload, valid when ctg==10
// - cur_scheme  in   48  scheme payload, valid when ctg==11
// - pkt_start   in   1   one-clock trigger from the packet detector
// - working     out  1   high in SEND and GAP; holds the demodulator in flush
// - mod_out     out  1   registered modulation bit
// - busy        out  1   high in SEND and GAP
// - seq_done    out  1   one-clock pulse when the final repeat completes
// - act_flag    out  8   active flag: [7:4] repeats-1, [3:0] bit-period multiplier-1
// - err_overrun out  1   sticky; set when a pending scheme is overwritten
// BEHAVIOUR
// - Reset: all outputs 0. last_ord=0, scheme_valid=0, pending_valid=0, state IDLE.
// - Event detect: register last_ord. ord!=last_ord -> evt for 1 clock, then last_ord<=ord.
//   2-bit wrap (3->0) counts as a change. The effect of evt is visible on the clock after ord changes.
// - ctg 10: act_flag<=cur_flag in any state. A change mid-burst takes effect at the next bit boundary.
// - ctg 11:
//   - Not in SEND/GAP: active_scheme<=cur_scheme, scheme_valid=1, state->ARMED.
//   - In SEND/GAP: load into pending and set pending_valid. If pending_valid was already 1,
//     overwrite pending and set err_overrun.
// - ctg 01: immediate abort from any state. mod_out=0, working=0, scheme_valid=0,
//   pending_valid=0, state->IDLE. No seq_done pulse.
// - States:
//   - IDLE: wait for a scheme load.
//   - ARMED: pkt_start -> SEND. bit_idx=NBITS-1, rep=act_flag[7:4], period counter cleared.
//   - SEND:
//     - mod_out=active_scheme[bit_idx], MSB first. The first bit appears on the clock after pkt_start.
//     - Each bit is held BIT_CYCLES*(act_flag[3:0]+1) clocks.
//     - After bit 0: rep!=0 -> rep-1, go to GAP; rep==0 -> pulse seq_done, go to ARMED.
//   - GAP: mod_out=0 for GAP_CYCLES clocks, then SEND from bit NBITS-1.
// - pkt_start is ignored outside ARMED (no queuing).
// - End of burst with pending_valid: active_scheme<=pending, pending_valid=0. This happens in the
//   same clock as the ARMED transition.
// - Simultaneous pkt_start and ctg-11 evt in ARMED: the burst uses the old active_scheme;
//   the new payload goes to pending.
// - Simultaneous pkt_start and ctg-01 evt: abort wins.
// - Reset mid-burst: outputs 0 next clock; err_overrun cleared.
// - Counters: period counter 14 bits (max 50*16=800 at defaults), gap counter 11 bits,
//   bit_idx 6 bits, rep 4 bits. No counter wraps in valid operation.
// STRUCTURE
// - Shared package: CTG_ABORT=2'b01, CTG_FLAG=2'b10, CTG_SCHEME=2'b11, and the state encoding
//   IDLE/ARMED/SEND/GAP.
// - One sub-module, bit_timer: loadable down-counter with a terminal-count pulse. It is used for
//   both the bit period and GAP_CYCLES.
// - The rest is one FSM plus payload registers, in one file.
// TESTING
// - Reset then idle: all outputs 0. pkt_start pulses give no mod_out activity and working stays 0.
// - Flag then scheme, then trigger:
//   - Stimulus: ord 0->1 ctg10 flag=8'h00; ord 1->2 ctg11 scheme=48'hA5A5_0000_FFFF; pkt_start.
//   - Response: mod_out=1,0,1,0,... with 50 clocks per bit. Burst is 2400 clocks, working high
//     throughout, then seq_done and ARMED.
// - flag=8'h21 (3 bursts, x2 period): 100 clocks per bit. Two GAPs of 500 clocks each.
//   seq_done pulses once, only after the third burst.
// - Two ctg11 messages during SEND: the first goes to pending. The second sets err_overrun.
//   The next burst transmits the second payload.
// - ctg01 mid-SEND at bit 20: mod_out=0 and working=0 the next clock. No seq_done.
//   A following pkt_start is ignored.
// - ord wrap 3->0 with ctg11 is detected as a load. A constant ord yields no event over 1000 clocks.

Source files
------------

// File: rtl/scheme_sequencer_pkg.sv
// Shared constants, state encoding and timing helper for the scheme sequencer.
package scheme_sequencer_pkg;

    localparam logic [1:0] CTG_ABORT  = 2'b01;
    localparam logic [1:0] CTG_FLAG   = 2'b10;
    localparam logic [1:0] CTG_SCHEME = 2'b11;

    localparam int PER_W = 14;
    localparam int GAP_W = 11;
    localparam int IDX_W = 6;
    localparam int REP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SEND,
        ST_GAP
    } state_t;

    // Bit hold time minus one, as loaded into the down-counter.
    function automatic logic [PER_W-1:0] bit_period_m1(input int base,
                                                       input logic [3:0] mult);
        return PER_W'(base * (int'(mult) + 1) - 1);
    endfunction

endpackage

// File: rtl/scheme_sequencer_if.sv
// Demodulator-side message bus and tag modulation outputs.
interface scheme_sequencer_if #(
    parameter int NBITS = 48
);
    logic [1:0]       ord;
    logic [1:0]       ctg;
    logic [7:0]       cur_flag;
    logic [NBITS-1:0] cur_scheme;
    logic             pkt_start;
    logic             working;
    logic             mod_out;
    logic             busy;
    logic             seq_done;
    logic [7:0]       act_flag;
    logic             err_overrun;

    modport master (
        output ord, ctg, cur_flag, cur_scheme, pkt_start,
        input  working, mod_out, busy, seq_done, act_flag, err_overrun
    );

    modport slave (
        input  ord, ctg, cur_flag, cur_scheme, pkt_start,
        output working, mod_out, busy, seq_done, act_flag, err_overrun
    );
endinterface

// File: rtl/scheme_sequencer_bit_timer.sv
// Loadable down-counter; tc_o is high once the loaded count has run out.
module bit_timer #(
    parameter int WIDTH = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] val_i,
    output logic             tc_o
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/scheme_sequencer.sv
// Latches flag/scheme messages from the demodulator and serialises the
// scheme onto the modulation line, one burst set per packet trigger.
module scheme_sequencer
    import scheme_sequencer_pkg::*;
#(
    parameter int BIT_CYCLES = 50,
    parameter int GAP_CYCLES = 500,
    parameter int NBITS      = 48
) (
    input logic               clock,
    input logic               reset,
    scheme_sequencer_if.slave bus
);
    state_t             state_q;
    logic [1:0]         last_ord_q;
    logic [7:0]         act_flag_q;
    logic [NBITS-1:0]   active_q;
    logic [NBITS-1:0]   pending_q;
    logic               scheme_valid_q;
    logic               pending_valid_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [REP_W-1:0]   rep_q;
    logic               mod_q;
    logic               working_q;
    logic               done_q;
    logic               err_q;

    logic evt;
    logic ev_abort;
    logic ev_flag;
    logic ev_scheme;
    logic in_burst;
    logic start;
    logic bit_tc;
    logic gap_tc;
    logic bit_end;
    logic last_bit;
    logic consume;
    logic bit_load;
    logic gap_load;

    assign evt       = (bus.ord != last_ord_q);
    assign ev_abort  = evt && (bus.ctg == CTG_ABORT);
    assign ev_flag   = evt && (bus.ctg == CTG_FLAG);
    assign ev_scheme = evt && (bus.ctg == CTG_SCHEME);
    assign in_burst  = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign start     = (state_q == ST_ARMED) && bus.pkt_start
                     && scheme_valid_q && !ev_abort;
    assign bit_end   = (state_q == ST_SEND) && bit_tc;
    assign last_bit  = bit_end && (bit_idx_q == '0);
    assign consume   = last_bit && (rep_q == '0) && pending_valid_q;
    assign bit_load  = start
                     || (bit_end && (bit_idx_q != '0))
                     || ((state_q == ST_GAP) && gap_tc);
    assign gap_load  = last_bit && (rep_q != '0);

    bit_timer #(.WIDTH(PER_W)) u_bit_timer (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (bit_load),
        .val_i  (bit_period_m1(BIT_CYCLES, act_flag_q[3:0])),
        .tc_o   (bit_tc)
    );

    bit_timer #(.WIDTH(GAP_W)) u_gap_timer (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (gap_load),
        .val_i  (GAP_W'(GAP_CYCLES - 1)),
        .tc_o   (gap_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_ord_q      <= '0;
            act_flag_q      <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            scheme_valid_q  <= 1'b0;
            pending_valid_q <= 1'b0;
            bit_idx_q       <= '0;
            rep_q           <= '0;
            mod_q           <= 1'b0;
            working_q       <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            last_ord_q <= bus.ord;
            if (ev_flag) begin
                act_flag_q <= bus.cur_flag;
            end
            if (ev_abort) begin
                state_q         <= ST_IDLE;
                mod_q           <= 1'b0;
                working_q       <= 1'b0;
                scheme_valid_q  <= 1'b0;
                pending_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                    end
                    ST_ARMED: begin
                        if (start) begin
                            state_q   <= ST_SEND;
                            bit_idx_q <= IDX_W'(NBITS - 1);
                            rep_q     <= act_flag_q[7:4];
                            mod_q     <= active_q[NBITS-1];
                            working_q <= 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (bit_end && (bit_idx_q != '0)) begin
                            bit_idx_q <= bit_idx_q - 1'b1;
                            mod_q     <= active_q[bit_idx_q - 1'b1];
                        end else if (gap_load) begin
                            rep_q   <= rep_q - 1'b1;
                            state_q <= ST_GAP;
                            mod_q   <= 1'b0;
                        end else if (last_bit) begin
                            state_q   <= ST_ARMED;
                            mod_q     <= 1'b0;
                            working_q <= 1'b0;
                            done_q    <= 1'b1;
                            if (pending_valid_q) begin
                                active_q        <= pending_q;
                                pending_valid_q <= 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_tc) begin
                            state_q   <= ST_SEND;
                            bit_idx_q <= IDX_W'(NBITS - 1);
                            mod_q     <= active_q[NBITS-1];
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
                // A trigger in the same clock keeps the old scheme on air.
                if (ev_scheme) begin
                    if (in_burst || start) begin
                        pending_q       <= bus.cur_scheme;
                        pending_valid_q <= 1'b1;
                        if (pending_valid_q && !consume) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        active_q       <= bus.cur_scheme;
                        scheme_valid_q <= 1'b1;
                        state_q        <= ST_ARMED;
                    end
                end
            end
        end
    end

    assign bus.mod_out     = mod_q;
    assign bus.working     = working_q;
    assign bus.busy        = working_q;
    assign bus.seq_done    = done_q;
    assign bus.act_flag    = act_flag_q;
    assign bus.err_overrun = err_q;
endmodule
